// File: rtl/burst_handshake_src_if.sv
// Valid/ready bus between the burst source and the downstream register slice.
// The master side offers data words; the slave side returns ready.
interface burst_handshake_src_if #(
  parameter int WIDTH = 8
);
  logic             src_vaild;
  logic [WIDTH-1:0] src_data_out;
  logic             src_ready;

  modport master (
    output src_vaild,
    output src_data_out,
    input  src_ready
  );

  modport slave (
    input  src_vaild,
    input  src_data_out,
    output src_ready
  );
endinterface

// File: rtl/burst_handshake_src.sv
// Burst source: emits bursts of incrementing data words on a valid/ready bus.
// Every output is registered, so src_vaild never depends combinationally on
// src_ready. idle is held high between bursts so the downstream slice can see
// burst edges, and a fixed gap of IDLE_GAP cycles follows every burst.
module burst_handshake_src #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 256,
  parameter  int IDLE_GAP = 4,
  localparam int LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  s_rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [WIDTH-1:0]      seed,
  input  logic                  hold,
  burst_handshake_src_if.master src,
  output logic                  idle,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      beat_cnt
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_nxt;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] seed_nxt;
  logic [LEN_W-1:0] beat_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             vld_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             idle_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  logic             xfer;
  logic             len_ok;
  logic [LEN_W-1:0] beat_inc;
  logic             last_beat;

  // A beat moves when the offered word meets ready at a rising edge.
  assign xfer      = src.src_vaild & src.src_ready;
  // Zero-length and oversize requests are dropped rather than clamped.
  assign len_ok    = (burst_len != '0) && (burst_len <= LEN_W'(DEPTH));
  assign beat_inc  = beat_cnt + LEN_W'(1);
  assign last_beat = (beat_inc == len_q);

  // Next-state and next-output decode; every target defaults to holding.
  always_comb begin
    state_nxt    = state;
    len_nxt      = len_q;
    seed_nxt     = seed_q;
    beat_cnt_nxt = beat_cnt;
    gap_cnt_nxt  = gap_cnt;
    vld_nxt      = src.src_vaild;
    data_nxt     = src.src_data_out;
    idle_nxt     = idle;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && len_ok) begin
          state_nxt    = ST_SEND;
          len_nxt      = burst_len;
          seed_nxt     = seed;
          beat_cnt_nxt = '0;
          // First beat goes out immediately unless hold defers it.
          vld_nxt      = ~hold;
          data_nxt     = seed;
          idle_nxt     = 1'b0;
          busy_nxt     = 1'b1;
        end
      end

      ST_SEND: begin
        if (xfer) begin
          beat_cnt_nxt = beat_inc;
          if (last_beat) begin
            state_nxt   = ST_GAP;
            vld_nxt     = 1'b0;
            done_nxt    = 1'b1;
            idle_nxt    = 1'b1;
            gap_cnt_nxt = '0;
          end else begin
            // Next word is seed plus beats already moved, wrapping at 2^WIDTH.
            // It is loaded even when hold drops valid so a later re-offer
            // simply raises valid over an already correct word.
            vld_nxt  = ~hold;
            data_nxt = seed_q + WIDTH'(beat_inc);
          end
        end else if (!src.src_vaild) begin
          // Bubble in progress: re-offer once hold is released. A pending
          // beat is never retracted, so hold is ignored while valid is high.
          vld_nxt = ~hold;
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst context, counters and all registered outputs.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      len_q            <= '0;
      seed_q           <= '0;
      beat_cnt         <= '0;
      gap_cnt          <= '0;
      src.src_vaild    <= 1'b0;
      src.src_data_out <= '0;
      idle             <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      len_q            <= len_nxt;
      seed_q           <= seed_nxt;
      beat_cnt         <= beat_cnt_nxt;
      gap_cnt          <= gap_cnt_nxt;
      src.src_vaild    <= vld_nxt;
      src.src_data_out <= data_nxt;
      idle             <= idle_nxt;
      busy             <= busy_nxt;
      done             <= done_nxt;
    end
  end

endmodule
